// File: rtl/pwm_peripheral.sv
// 16-pin PWM/static output block with write-only register file.
// Ports: clk, rst_n, wr_en/wr_addr/wr_data (register writes), out[15:0], pwm_sync.
module pwm_peripheral #(
  parameter int PRESCALE = 3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [15:0] out,
  output logic        pwm_sync
);

  localparam logic [11:0] PRE_MAX = 12'(PRESCALE - 1);

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [7:0]  duty_act;
  logic [11:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  cnt_nxt;
  logic [7:0]  act_nxt;
  logic        tick;
  logic        wrap;
  logic        pwm_sig;
  logic [15:0] out_nxt;

  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // Compare against the post-edge counter and shadow so the first
  // output update of a period lands in the same cycle as pwm_sync.
  always_comb begin
    cnt_nxt = tick ? pwm_cnt + 8'd1 : pwm_cnt;
    act_nxt = wrap ? duty : duty_act;
    pwm_sig = (act_nxt == 8'hFF) || (cnt_nxt < act_nxt);
    out_nxt = en_out & (~en_pwm | {16{pwm_sig}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_out   <= '0;
      en_pwm   <= '0;
      duty     <= '0;
      duty_act <= '0;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      out      <= '0;
      pwm_sync <= 1'b0;
    end else begin
      pre_cnt  <= tick ? 12'd0 : pre_cnt + 12'd1;
      pwm_cnt  <= cnt_nxt;
      duty_act <= act_nxt;
      pwm_sync <= wrap;
      out      <= out_nxt;
      if (wr_en) begin
        unique case (wr_addr)
          7'h00:   en_out[7:0]  <= wr_data;
          7'h01:   en_out[15:8] <= wr_data;
          7'h02:   en_pwm[7:0]  <= wr_data;
          7'h03:   en_pwm[15:8] <= wr_data;
          7'h04:   duty         <= wr_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral (PRESCALE=4).
module tb_pwm_peripheral;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] out;
  logic        pwm_sync;

  int nchk;
  int nerr;

  pwm_peripheral #(.PRESCALE(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .out(out),
    .pwm_sync(pwm_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_sync();
    int n;
    n = 0;
    while (!pwm_sync && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!pwm_sync) check("wait_sync_timeout", 0, 1);
  endtask

  // Starts in a pwm_sync cycle; ends in the next one.
  task automatic measure(input int wr_at, input logic [7:0] val,
                         output int hi, output int len);
    hi = 0;
    len = 0;
    for (int i = 0; i < 2000; i++) begin
      wr_en = (i == wr_at);
      wr_addr = 7'h04;
      wr_data = val;
      hi += int'(out[0]);
      @(negedge clk);
      len = i + 1;
      if (pwm_sync) break;
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int hi, len, n;
    nchk = 0;
    nerr = 0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    vt[0] = '{7'h00, 8'hA5, 16'h00A5};
    vt[1] = '{7'h01, 8'h3C, 16'h3CA5};
    vt[2] = '{7'h02, 8'hFF, 16'h3C00};
    vt[3] = '{7'h02, 8'h00, 16'h3CA5};
    vt[4] = '{7'h05, 8'hFF, 16'h3CA5};
    vt[5] = '{7'h7F, 8'hFF, 16'h3CA5};
    vt[6] = '{7'h03, 8'hF0, 16'h0CA5};
    vt[7] = '{7'h03, 8'h00, 16'h3CA5};
    vt[8] = '{7'h04, 8'h00, 16'h3CA5};

    @(negedge clk);
    do_reset();
    check("reset_out", int'(out), 0);
    check("reset_sync", int'(pwm_sync), 0);

    for (int k = 0; k < 9; k++) begin
      wr(vt[k].addr, vt[k].data);
      check("vec_1clk_old", int'(out),
            int'(k == 0 ? 16'h0000 : vt[k-1].exp));
      @(negedge clk);
      check($sformatf("vec%0d_out", k), int'(out), int'(vt[k].exp));
    end

    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out != 16'h3CA5) n++;
      @(negedge clk);
    end
    check("static_no_toggle", n, 0);

    wr_en = 1'b1;
    wr_addr = 7'h00;
    wr_data = 8'h11;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("b2b_last_wins", int'(out), 16'h3C22);

    do_reset();
    check("reset2_out", int'(out), 0);
    wr(7'h00, 8'h01);
    wr(7'h01, 8'h00);
    wr(7'h02, 8'h01);
    wr(7'h03, 8'h00);
    wr(7'h04, 8'h80);
    wait_sync();
    measure(-1, 8'h00, hi, len);
    check("d80_high", hi, 512);
    check("d80_len", len, 1024);

    wr(7'h04, 8'hFF);
    wait_sync();
    for (int p = 0; p < 2; p++) begin
      measure(-1, 8'h00, hi, len);
      check("dFF_high", hi, 1024);
      check("dFF_len", len, 1024);
    end

    wr(7'h04, 8'h00);
    wait_sync();
    for (int p = 0; p < 2; p++) begin
      measure(-1, 8'h00, hi, len);
      check("d00_high", hi, 0);
      check("d00_len", len, 1024);
    end

    wr(7'h04, 8'h40);
    wait_sync();
    measure(100, 8'hC0, hi, len);
    check("shadow_cur", hi, 256);
    measure(-1, 8'h00, hi, len);
    check("shadow_next", hi, 768);
    measure(1023, 8'h20, hi, len);
    check("wraptick_cur", hi, 768);
    check("wraptick_len", len, 1024);
    measure(-1, 8'h00, hi, len);
    check("wraptick_p1", hi, 768);
    measure(-1, 8'h00, hi, len);
    check("wraptick_p2", hi, 128);

    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    repeat (300) @(negedge clk);
    check("pre_rst_hi", int'(out[15:8]), 8'hFF);
    rst_n = 1'b0;
    wr_en = 1'b1;
    wr_addr = 7'h00;
    wr_data = 8'h5A;
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    check("midrst_out", int'(out), 0);
    check("midrst_sync", int'(pwm_sync), 0);
    n = 0;
    while (!pwm_sync && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_first_sync", n, 1024);
    check("midrst_out_after", int'(out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter PRESCALE, default 3000, meaning system clocks per PWM count step (legal range 1..4095).
REQ-002 SHALL have port clk, input, 1, system clock, with all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port wr_en, input, 1, one-cycle register write strobe from the SPI peripheral stage.
REQ-005 SHALL have port wr_addr, input, 7, register address.
REQ-006 SHALL have port wr_data, input, 8, register write data.
REQ-007 SHALL have port out, output, 16, registered output pins.
REQ-008 SHALL have port pwm_sync, output, 1, registered one-cycle pulse at each PWM period start.

Function
REQ-009 SHALL hold five 8-bit registers: 0x00 en_out[7:0], 0x01 en_out[15:8], 0x02 en_pwm[7:0], 0x03 en_pwm[15:8], 0x04 duty.
REQ-010 SHALL write wr_data into the addressed register at the rising edge where wr_en=1; addresses 0x05..0x7F are ignored, with no state change.
REQ-011 SHALL treat wr_en held high on consecutive cycles as one write per cycle; the last write to the same address wins.
REQ-012 SHALL run prescale counter pre_cnt (12 bit) 0..PRESCALE-1, wrapping to 0; tick=1 in the cycle pre_cnt==PRESCALE-1; PRESCALE=1 gives tick every cycle.
REQ-013 SHALL increment 8-bit pwm_cnt on each tick, wrapping 255->0 (period = 256*PRESCALE clocks).
REQ-014 SHALL load shadow register duty_act from duty on the tick where pwm_cnt wraps 255->0, so duty changes never take effect mid-period.
REQ-015 SHALL use the duty register value as it stood before that edge when a duty write coincides with the wrap tick; the new value applies from the next period.
REQ-016 SHALL define pwm_sig = 1 when duty_act==0xFF, else (pwm_cnt < duty_act); duty_act==0 gives constant 0.
REQ-017 SHALL compute per bit i: out[i] <= en_out[i] ? (en_pwm[i] ? pwm_sig : 1) : 0, registered.
REQ-018 SHALL make out reflect a write to en_out/en_pwm two clocks after the wr_en cycle (register edge, then output edge).
REQ-019 SHALL give an en_pwm bit no effect while its en_out bit is 0.
REQ-020 SHALL assert pwm_sync for exactly one clock, in the cycle after the wrap tick (aligned with the first out update of the new period).
REQ-021 SHALL keep the counters free-running regardless of enable registers.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, clear all five registers, duty_act, pre_cnt, pwm_cnt, out (0x0000) and pwm_sync (0).
REQ-023 SHALL ignore wr_en in reset cycles.
REQ-024 SHALL, on reset mid-period, restart with pre_cnt=0 and pwm_cnt=0 on the first non-reset cycle, with no pwm_sync until the next wrap.

Verification
REQ-025 SHALL cover static enable: write 0x00<-0xA5 and 0x01<-0x3C -> out=0x3CA5 two clocks after the second strobe; no toggling.
REQ-026 SHALL cover 50% duty with PRESCALE=4: en_out[0]=1, en_pwm[0]=1, duty=0x80 -> after next pwm_sync, out[0] high 512 clocks and low 512 clocks per 1024-clock period.
REQ-027 SHALL cover the extremes duty=0x00 and duty=0xFF: out[0] constant 0 and constant 1 across two full periods; pwm_sync period exactly 1024 clocks.
REQ-028 SHALL cover shadowing: duty 0x40->0xC0 written mid-period -> current period high 256 clocks, next period high 768 clocks; a write on the wrap tick applies one period later.
REQ-029 SHALL cover an illegal address: write 0x05 and 0x7F <- 0xFF -> all registers unchanged, out unchanged.
REQ-030 SHALL cover reset mid-operation: assert rst_n=0 for 1 cycle during PWM -> out=0x0000, pwm_sync=0; first pwm_sync 1024 clocks after release (PRESCALE=4).
